stream_src: RTL and testbench

Synthesizable val/rdy stream source that plays a preloaded list of messages into a DUT input port, one message per handshake, with a configurable gap between messages. It is the transmitting counterpart to the team's stream sinks and sits on the test-harness side of any val/rdy DUT input. Messages are loaded through a small write port, and playback begins on a start pulse. The block reports progress and completion to the harness.

---
 rtl/stream_src.sv | 80 ++++++++
 tb/tb_stream_src.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/stream_src.sv
// stream_src: val/rdy stream source that plays preloaded messages with a configurable inter-message gap
module stream_src #(
   parameter int p_msg_nbits       = 32,
   parameter int p_max_msgs        = 16,
   parameter int p_send_intv_delay = 0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           cfg_wen,
   input  logic [$clog2(p_max_msgs)-1:0]  cfg_addr,
   input  logic [p_msg_nbits-1:0]         cfg_wdata,
   input  logic [$clog2(p_max_msgs):0]    num_msgs,
   input  logic                           start,
   output logic [p_msg_nbits-1:0]         msg,
   output logic                           val,
   input  logic                           rdy,
   output logic                           busy,
   output logic                           done,
   output logic [$clog2(p_max_msgs):0]    sent_count
);
   localparam int AW = $clog2(p_max_msgs);
   localparam int CW = AW + 1;
   localparam int DW = p_send_intv_delay > 1 ? $clog2(p_send_intv_delay) : 1;
   typedef enum logic [1:0] {IDLE, DELAY, SEND, DONE} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] n_q, n_d, cnt_q, cnt_d;
   logic [DW-1:0] dly_q, dly_d;
   logic [p_msg_nbits-1:0] mem_q [p_max_msgs];
   logic cfg_ok, dly_last;
   // idx is the count of completed transfers, so the low bits of sent_count address the memory
   assign cfg_ok     = state_q == IDLE || state_q == DONE;
   assign dly_last   = dly_q == DW'(p_send_intv_delay - 1);
   assign val        = state_q == SEND;
   assign msg        = val ? mem_q[cnt_q[AW-1:0]] : '0;
   assign busy       = state_q == DELAY || state_q == SEND;
   assign done       = state_q == DONE;
   assign sent_count = cnt_q;
   // message memory, writable only while not playing; contents survive reset
   always_ff @(posedge clk) begin
      if (cfg_wen && cfg_ok) mem_q[cfg_addr] <= cfg_wdata;
   end
   // state, latched count, transfer count and gap counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         n_q     <= '0;
         cnt_q   <= '0;
         dly_q   <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         cnt_q   <= cnt_d;
         dly_q   <= dly_d;
      end
   end
   // next-state: start latches min(num_msgs, depth); each transfer advances and may re-enter the gap
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      cnt_d   = cnt_q;
      dly_d   = dly_q;
      case (state_q)
         IDLE, DONE: if (start) begin
            n_d     = num_msgs > CW'(p_max_msgs) ? CW'(p_max_msgs) : num_msgs;
            cnt_d   = '0;
            dly_d   = '0;
            state_d = n_d == '0 ? DONE : (p_send_intv_delay > 0 ? DELAY : SEND);
         end
         DELAY: begin
            dly_d   = dly_last ? '0 : dly_q + DW'(1);
            state_d = dly_last ? SEND : DELAY;
         end
         SEND: if (rdy) begin
            cnt_d   = cnt_q + CW'(1);
            state_d = cnt_d == n_q ? DONE : (p_send_intv_delay > 0 ? DELAY : SEND);
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_stream_src.sv
// tb_stream_src: random/directed playback on zero-gap and two-cycle-gap sources against a transfer-level model
module tb_stream_src;
   logic clk = 1'b0, rst = 1'b1, cfg_wen = 1'b0, start = 1'b0, rdy = 1'b0;
   logic [3:0]  cfg_addr = '0;
   logic [31:0] cfg_wdata = '0;
   logic [4:0]  num_msgs = '0;
   logic [31:0] o_msg [2];
   logic        o_val [2], o_busy [2], o_done [2];
   logic [4:0]  o_sc [2];
   int checks = 0, errors = 0;
   logic [31:0] m_mem [2][16];
   int  m_n [2], m_sent [2], m_gap [2];
   bit  m_act [2], m_done [2];

   always #5 clk = ~clk;

   stream_src #(.p_msg_nbits(32), .p_max_msgs(16), .p_send_intv_delay(0)) dut0 (
      .clk(clk), .rst(rst), .cfg_wen(cfg_wen), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .num_msgs(num_msgs), .start(start), .msg(o_msg[0]), .val(o_val[0]), .rdy(rdy),
      .busy(o_busy[0]), .done(o_done[0]), .sent_count(o_sc[0]));

   stream_src #(.p_msg_nbits(32), .p_max_msgs(16), .p_send_intv_delay(2)) dut2 (
      .clk(clk), .rst(rst), .cfg_wen(cfg_wen), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .num_msgs(num_msgs), .start(start), .msg(o_msg[1]), .val(o_val[1]), .rdy(rdy),
      .busy(o_busy[1]), .done(o_done[1]), .sent_count(o_sc[1]));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_act[k] = 0; m_done[k] = 0; m_sent[k] = 0; m_n[k] = 0; m_gap[k] = 0;
      end
   endtask

   // one clock edge of behaviour: gap of d idle cycles, then offer mem[sent] until accepted
   task automatic model_upd();
      for (int k = 0; k < 2; k++) begin
         int d = k ? 2 : 0;
         if (rst) begin
            m_act[k] = 0; m_done[k] = 0; m_sent[k] = 0; m_n[k] = 0;
         end else if (!m_act[k]) begin
            if (cfg_wen) m_mem[k][cfg_addr] = cfg_wdata;
            if (start) begin
               m_n[k]    = num_msgs > 16 ? 16 : int'(num_msgs);
               m_sent[k] = 0;
               m_done[k] = m_n[k] == 0;
               m_act[k]  = m_n[k] != 0;
               m_gap[k]  = d;
            end
         end else if (m_gap[k] > 0) m_gap[k]--;
         else if (rdy) begin
            m_sent[k]++;
            if (m_sent[k] == m_n[k]) begin
               m_act[k] = 0; m_done[k] = 1;
            end else m_gap[k] = d;
         end
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 2; k++) begin
         bit v = m_act[k] && m_gap[k] == 0;
         chk($sformatf("d%0d val", k), o_val[k], v);
         chk($sformatf("d%0d msg", k), o_msg[k], v ? m_mem[k][m_sent[k]] : 32'h0);
         chk($sformatf("d%0d busy", k), o_busy[k], m_act[k]);
         chk($sformatf("d%0d done", k), o_done[k], m_done[k]);
         chk($sformatf("d%0d sent_count", k), o_sc[k], m_sent[k]);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_upd();
      @(negedge clk);
      check_all();
   endtask

   task automatic go(input int nm);
      num_msgs = nm[4:0];
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   // mode 0: rdy high, 1: 0,1,0,0,1 pattern, 2: random
   task automatic run(input int mode);
      int c = 0;
      bit pat [5] = '{0, 1, 0, 0, 1};
      while ((m_act[0] || m_act[1]) && c < 400) begin
         rdy = mode == 0 ? 1'b1 : mode == 1 ? pat[c % 5] : 1'($urandom_range(0, 1));
         cyc();
         c++;
      end
      chk("run bound", c < 400, 1'b1);
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      check_all();
      cyc();
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         cfg_wen = 1'b1; cfg_addr = i[3:0];
         cfg_wdata = i < 4 ? 32'h11 * (i + 1) : $urandom;
         cyc();
      end
      cfg_wen = 1'b0;
      rdy = 1'b1;
      go(4);
      chk("t1 first msg", o_msg[0], 32'h11);
      run(0);
      chk("t1 sent_count", o_sc[0], 4);
      chk("t1 done", o_done[0], 1);
      go(4);
      run(1);
      go(2);
      run(0);
      chk("gap sent_count", o_sc[1], 2);
      go(0);
      chk("n0 done", o_done[0], 1);
      chk("n0 val", o_val[0], 0);
      run(0);
      go(20);
      run(2);
      chk("sat sent_count0", o_sc[0], 16);
      chk("sat sent_count2", o_sc[1], 16);
      rdy = 1'b0;
      go(4);
      cyc();
      cyc();
      chk("pre-rst val", o_val[1], 1);
      #2 rst = 1'b1;
      #1 model_reset();
      check_all();
      cyc();
      rst = 1'b0;
      go(4);
      run(0);
      cfg_wen = 1'b1; cfg_addr = 4'd0; cfg_wdata = 32'h99;
      go(3);
      cfg_wen = 1'b0;
      chk("wr+start msg", o_msg[0], 32'h99);
      cfg_wen = 1'b1; cfg_addr = 4'd1; cfg_wdata = 32'hdead;
      rdy = 1'b0;
      cyc();
      cfg_wen = 1'b0;
      run(2);
      go(4);
      run(0);
      for (int r = 0; r < 8; r++) begin
         for (int w = 0; w < 3; w++) begin
            cfg_wen = 1'b1; cfg_addr = 4'($urandom_range(0, 15)); cfg_wdata = $urandom;
            cyc();
         end
         cfg_wen = 1'b0;
         go($urandom_range(0, 20));
         run(r % 3);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
